c4_game_engine: RTL and testbench

C4_GAME_ENGINE -- requirements
Module: c4_game_engine

---
 rtl/c4_pkg.sv | 28 ++
 rtl/c4_cursor.sv | 90 +++++++++
 rtl/c4_game_engine.sv | 211 +++++++++++++++++++++
 tb/tb_c4_game_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// rtl/c4_pkg.sv - cell/state encodings and scan direction table for the connect-four engine
package c4_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_DROP,
        ST_SCAN,
        ST_OVER
    } state_t;

    localparam int NUM_DIRS = 4;

    // Row/column step per direction: horizontal, vertical, diagonal, anti-diagonal
    localparam logic signed [1:0] DIR_DROW [NUM_DIRS] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1};
    localparam logic signed [1:0] DIR_DCOL [NUM_DIRS] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

    function automatic cell_t other_player(input cell_t p);
        return (p == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/c4_cursor.sv
// rtl/c4_cursor.sv - saturating column cursor; C4_AUTOREPEAT_EN turns left/right into held levels
// with one extra step per REPEAT_TICKS tick pulses.
module c4_cursor
    import c4_pkg::*;
#(
    parameter int COLS         = 7,
    parameter int REPEAT_TICKS = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     Resetn,
    input  logic                     i_clear,
    input  logic                     i_enable,
    input  logic                     i_left,
    input  logic                     i_right,
    input  logic                     i_tick,
    output logic [$clog2(COLS)-1:0]  o_col
);

    localparam int CW = $clog2(COLS);
    localparam logic [CW-1:0] COL_HOME = CW'(COLS / 2);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);

    logic [CW-1:0] r_col;
    logic          r_left_q;
    logic          r_right_q;
    logic          w_left_rise;
    logic          w_right_rise;
    logic          w_go_left;
    logic          w_go_right;
    logic          w_step_left;
    logic          w_step_right;

    assign w_left_rise  = i_left  & ~r_left_q;
    assign w_right_rise = i_right & ~r_right_q;
    // Both directions held at once cancel out
    assign w_go_left    = i_left  & ~i_right;
    assign w_go_right   = i_right & ~i_left;

`ifdef C4_AUTOREPEAT_EN
    localparam int TW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(REPEAT_TICKS - 1);

    logic [TW-1:0] r_tick_cnt;
    logic          w_repeat;

    assign w_repeat = i_tick && (r_tick_cnt == TICK_LAST) && !w_left_rise && !w_right_rise;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_tick_cnt <= '0;
        end else if (!(w_go_left || w_go_right) || w_left_rise || w_right_rise) begin
            r_tick_cnt <= '0;
        end else if (i_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
        end
    end

    assign w_step_left  = w_go_left  & (w_left_rise  | w_repeat);
    assign w_step_right = w_go_right & (w_right_rise | w_repeat);
`else
    logic w_tick_unused;
    assign w_tick_unused = i_tick & (REPEAT_TICKS != 0);

    assign w_step_left  = w_go_left  & w_left_rise;
    assign w_step_right = w_go_right & w_right_rise;
`endif

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_col     <= COL_HOME;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
        end else begin
            r_left_q  <= i_left;
            r_right_q <= i_right;
            if (i_clear) begin
                r_col <= COL_HOME;
            end else if (i_enable) begin
                if (w_step_left && (r_col != '0)) begin
                    r_col <= r_col - CW'(1);
                end else if (w_step_right && (r_col != COL_MAX)) begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign o_col = r_col;

endmodule

// File: rtl/c4_game_engine.sv
// rtl/c4_game_engine.sv - connect-four board, turn FSM and win/draw scanner (option: C4_AUTOREPEAT_EN)
module c4_game_engine
    import c4_pkg::*;
#(
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int WIN_LEN      = 4,
    parameter int REPEAT_TICKS = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic                     left,
    input  logic                     right,
    input  logic                     place,
    input  logic                     tick,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    output logic [1:0]               rd_cell,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic [1:0]               turn,
    output logic                     busy,
    output logic                     bad_move,
    output logic [1:0]               winner,
    output logic                     draw
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int FW = $clog2(ROWS + 1);
    localparam logic signed [5:0] ROWS_S = 6'(ROWS);
    localparam logic signed [5:0] COLS_S = 6'(COLS);
    localparam logic [3:0]        RUN_LAST  = 4'(WIN_LEN - 1);
    localparam logic [FW-1:0]     FILL_FULL = FW'(ROWS);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_board [ROWS][COLS];
    logic [FW-1:0]       r_fill  [COLS];
    cell_t               r_turn;
    logic [1:0]          r_winner;
    logic                r_draw;
    logic                r_bad_move;
    logic [RW-1:0]       r_prow;
    logic [CW-1:0]       r_pcol;
    logic [1:0]          r_dir;
    logic                r_sense;
    logic [3:0]          r_run;
    logic signed [5:0]   r_sr;
    logic signed [5:0]   r_sc;

    logic                w_busy;
    logic                w_start_ok;
    logic                w_in_turn;
    logic                w_col_full;
    logic                w_place_ok;
    logic                w_bad_place;
    logic                w_cursor_en;
    logic                w_all_full;
    logic signed [5:0]   w_dr;
    logic signed [5:0]   w_dc;
    logic signed [5:0]   w_nr;
    logic signed [5:0]   w_nc;
    logic                w_in_range;
    logic [1:0]          w_ncell;
    logic                w_match;
    logic                w_win;
    logic                w_scan_end;

    c4_cursor #(
        .COLS         (COLS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_cursor (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .i_clear  (w_start_ok),
        .i_enable (w_cursor_en),
        .i_left   (left),
        .i_right  (right),
        .i_tick   (tick),
        .o_col    (cur_col)
    );

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_TURN;
            ST_TURN: if (place && !w_col_full) w_next = ST_DROP;
            ST_DROP: w_next = ST_SCAN;
            ST_SCAN: begin
                if (w_win || (w_scan_end && w_all_full)) w_next = ST_OVER;
                else if (w_scan_end)                     w_next = ST_TURN;
            end
            ST_OVER: if (start) w_next = ST_TURN;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == ST_DROP) || (r_state == ST_SCAN);
        w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
        w_in_turn   = (r_state == ST_TURN);
        w_place_ok  = w_in_turn && place && !w_col_full;
        w_bad_place = w_in_turn && place && w_col_full;
        w_cursor_en = w_in_turn && !place;
    end

    assign w_col_full = (r_fill[cur_col] == FILL_FULL);

    always_comb begin
        w_all_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (r_fill[c] != FILL_FULL) w_all_full = 1'b0;
        end
    end

    // One scan step: look at the neighbour of the walk head in the current direction/sense
    always_comb begin
        w_dr = {{4{DIR_DROW[r_dir][1]}}, DIR_DROW[r_dir]};
        w_dc = {{4{DIR_DCOL[r_dir][1]}}, DIR_DCOL[r_dir]};
        if (r_sense) begin
            w_dr = -w_dr;
            w_dc = -w_dc;
        end
        w_nr       = r_sr + w_dr;
        w_nc       = r_sc + w_dc;
        w_in_range = (w_nr >= 6'sd0) && (w_nr < ROWS_S) && (w_nc >= 6'sd0) && (w_nc < COLS_S);
        w_ncell    = w_in_range ? r_board[w_nr[RW-1:0]][w_nc[CW-1:0]] : 2'b00;
        w_match    = w_in_range && (w_ncell == r_turn);
        w_win      = (r_state == ST_SCAN) && w_match && (r_run == RUN_LAST);
        w_scan_end = (r_state == ST_SCAN) && !w_match && r_sense && (r_dir == 2'd3);
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) r_board[r][c] <= 2'b00;
            end
            for (int c = 0; c < COLS; c++) r_fill[c] <= '0;
            r_turn     <= CELL_EMPTY;
            r_winner   <= 2'b00;
            r_draw     <= 1'b0;
            r_bad_move <= 1'b0;
            r_prow     <= '0;
            r_pcol     <= '0;
            r_dir      <= 2'd0;
            r_sense    <= 1'b0;
            r_run      <= 4'd0;
            r_sr       <= 6'sd0;
            r_sc       <= 6'sd0;
        end else begin
            r_bad_move <= w_bad_place;
            if (w_start_ok) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) r_board[r][c] <= 2'b00;
                end
                for (int c = 0; c < COLS; c++) r_fill[c] <= '0;
                r_turn   <= CELL_P1;
                r_winner <= 2'b00;
                r_draw   <= 1'b0;
            end
            if (w_place_ok) r_pcol <= cur_col;
            if (r_state == ST_DROP) begin
                r_board[r_fill[r_pcol][RW-1:0]][r_pcol] <= r_turn;
                r_fill[r_pcol] <= r_fill[r_pcol] + FW'(1);
                r_prow  <= r_fill[r_pcol][RW-1:0];
                r_sr    <= 6'(r_fill[r_pcol]);
                r_sc    <= 6'(r_pcol);
                r_dir   <= 2'd0;
                r_sense <= 1'b0;
                r_run   <= 4'd1;
            end
            if (r_state == ST_SCAN) begin
                if (w_match) begin
                    r_sr  <= w_nr;
                    r_sc  <= w_nc;
                    r_run <= r_run + 4'd1;
                end else if (!r_sense) begin
                    r_sense <= 1'b1;
                    r_sr    <= 6'(r_prow);
                    r_sc    <= 6'(r_pcol);
                end else begin
                    r_sense <= 1'b0;
                    r_dir   <= r_dir + 2'd1;
                    r_run   <= 4'd1;
                    r_sr    <= 6'(r_prow);
                    r_sc    <= 6'(r_pcol);
                end
                if (w_win) begin
                    r_winner <= r_turn;
                end else if (w_scan_end) begin
                    if (w_all_full) r_draw <= 1'b1;
                    else            r_turn <= other_player(r_turn);
                end
            end
        end
    end

    assign rd_cell  = ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) ? r_board[rd_row][rd_col] : 2'b00;
    assign turn     = r_turn;
    assign busy     = w_busy;
    assign bad_move = r_bad_move;
    assign winner   = r_winner;
    assign draw     = r_draw;

endmodule

// File: tb/tb_c4_game_engine.sv
// tb/tb_c4_game_engine.sv - directed bench for c4_game_engine (default 6x7x4 and a 4x4x3 instance)
module tb_c4_game_engine;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic       left, right, tick;
    logic       start, place, start4, place4;
    logic [2:0] rd_row, rd_col;
    logic [1:0] rd_row4, rd_col4;
    logic [1:0] rd_cell, turn, winner;
    logic [1:0] rd_cell4, turn4, winner4;
    logic [2:0] cur_col;
    logic [1:0] cur_col4;
    logic       busy, bad_move, draw;
    logic       busy4, bad_move4, draw4;

    int checks   = 0;
    int failures = 0;
    int exp_col [2];

    int seq_a [7]  = '{0, 1, 0, 1, 0, 1, 0};
    int seq_c [10] = '{1, 0, 2, 1, 3, 3, 2, 2, 3, 3};
    int seq_f [16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};

    always #10 CLOCK_50 = ~CLOCK_50;

    c4_game_engine dut (
        .CLOCK_50 (CLOCK_50), .Resetn (Resetn), .start (start), .left (left), .right (right),
        .place (place), .tick (tick), .rd_row (rd_row), .rd_col (rd_col), .rd_cell (rd_cell),
        .cur_col (cur_col), .turn (turn), .busy (busy), .bad_move (bad_move),
        .winner (winner), .draw (draw)
    );

    c4_game_engine #(.ROWS(4), .COLS(4), .WIN_LEN(3)) dut4 (
        .CLOCK_50 (CLOCK_50), .Resetn (Resetn), .start (start4), .left (left), .right (right),
        .place (place4), .tick (tick), .rd_row (rd_row4), .rd_col (rd_col4), .rd_cell (rd_cell4),
        .cur_col (cur_col4), .turn (turn4), .busy (busy4), .bad_move (bad_move4),
        .winner (winner4), .draw (draw4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_cell(input int sel, input int row, input int col, input logic [1:0] exp);
        if (sel != 0) begin
            rd_row4 = 2'(row);
            rd_col4 = 2'(col);
        end else begin
            rd_row = 3'(row);
            rd_col = 3'(col);
        end
        #1;
        check($sformatf("cell%0d_r%0d_c%0d", sel, row, col), (sel != 0) ? rd_cell4 : rd_cell, exp);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        exp_col[0] = 3;
        exp_col[1] = 2;
    endtask

    task automatic do_start(input int sel);
        @(negedge CLOCK_50);
        if (sel != 0) start4 = 1'b1; else start = 1'b1;
        @(negedge CLOCK_50);
        start  = 1'b0;
        start4 = 1'b0;
        exp_col[sel] = (sel != 0) ? 2 : 3;
        check("start_turn", (sel != 0) ? turn4 : turn, 1);
        check("start_col", (sel != 0) ? 32'(cur_col4) : 32'(cur_col), exp_col[sel]);
    endtask

    task automatic pulse_dir(input logic go_right);
        @(negedge CLOCK_50);
        if (go_right) right = 1'b1; else left = 1'b1;
        @(negedge CLOCK_50);
        right = 1'b0;
        left  = 1'b0;
    endtask

    task automatic move_to(input int sel, input int col);
        while (exp_col[sel] != col) begin
            pulse_dir(col > exp_col[sel]);
            exp_col[sel] += (col > exp_col[sel]) ? 1 : -1;
        end
        check("cur_col", (sel != 0) ? 32'(cur_col4) : 32'(cur_col), col);
    endtask

    task automatic place_at(input int sel, input int col, input int budget, input logic exp_bad);
        move_to(sel, col);
        @(negedge CLOCK_50);
        if (sel != 0) place4 = 1'b1; else place = 1'b1;
        @(negedge CLOCK_50);
        place  = 1'b0;
        place4 = 1'b0;
        check("bad_move", (sel != 0) ? bad_move4 : bad_move, exp_bad);
        for (int n = 0; n < budget && ((sel != 0) ? busy4 : busy); n++) @(negedge CLOCK_50);
        check("busy_done", (sel != 0) ? busy4 : busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Resetn = 1'b0;
        {left, right, tick, start, place, start4, place4} = '0;
        rd_row = '0; rd_col = '0; rd_row4 = '0; rd_col4 = '0;
        exp_col[0] = 3;
        exp_col[1] = 2;
        repeat (3) @(negedge CLOCK_50);

        check("rst_turn", turn, 0);
        check("rst_winner", winner, 0);
        check("rst_draw", draw, 0);
        check("rst_busy", busy, 0);
        check("rst_bad", bad_move, 0);
        check("rst_col", cur_col, 3);
        check("rst_col4", cur_col4, 2);
        check("rst_turn4", turn4, 0);
        check_cell(0, 0, 0, 2'b00);
        Resetn = 1'b1;

        // Vertical P1 win in column 0
        do_start(0);
        for (int i = 0; i < 7; i++) begin
            place_at(0, seq_a[i], 30, 1'b0);
            check("a_winner", winner, (i == 6) ? 1 : 0);
            check("a_turn", turn, (i == 6) ? 1 : ((i % 2 == 0) ? 2 : 1));
        end
        check("a_draw", draw, 0);
        check_cell(0, 3, 0, 2'b01);
        check_cell(0, 0, 1, 2'b10);
        check_cell(0, 4, 0, 2'b00);
        check_cell(0, 6, 0, 2'b00);
        check_cell(0, 0, 7, 2'b00);
        @(negedge CLOCK_50); place = 1'b1;
        @(negedge CLOCK_50); place = 1'b0;
        check("a_over_busy", busy, 0);
        check_cell(0, 4, 0, 2'b00);

        // Overfill column 3
        do_start(0);
        check_cell(0, 0, 0, 2'b00);
        check("b_winner", winner, 0);
        for (int i = 0; i < 6; i++) place_at(0, 3, 30, 1'b0);
        check("b_turn6", turn, 1);
        place_at(0, 3, 30, 1'b1);
        check("b_turn7", turn, 1);
        @(negedge CLOCK_50);
        check("b_bad_clr", bad_move, 0);
        check_cell(0, 5, 3, 2'b10);
        check_cell(0, 4, 3, 2'b01);
        check_cell(0, 0, 3, 2'b01);
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        check_cell(0, 0, 3, 2'b01);

        // Diagonal P2 win (0,0)..(3,3)
        do_reset();
        do_start(0);
        for (int i = 0; i < 10; i++) begin
            place_at(0, seq_c[i], 8 * 3 + 2, 1'b0);
            check("c_winner", winner, (i == 9) ? 2 : 0);
        end
        check("c_turn", turn, 2);
        check_cell(0, 3, 3, 2'b10);
        check_cell(0, 2, 3, 2'b01);

        // Cursor saturation
        do_start(0);
        pulse_dir(1'b1);
        check("d_step", cur_col, 4);
`ifdef C4_AUTOREPEAT_EN
        @(negedge CLOCK_50); right = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLOCK_50); tick = 1'b1;
            @(negedge CLOCK_50); tick = 1'b0;
        end
        right = 1'b0;
        @(negedge CLOCK_50);
`else
        for (int t = 0; t < 5; t++) pulse_dir(1'b1);
        for (int t = 0; t < 4; t++) begin
            @(negedge CLOCK_50); tick = 1'b1;
            @(negedge CLOCK_50); tick = 1'b0;
        end
`endif
        check("d_sat_hi", cur_col, 6);
        pulse_dir(1'b0);
        check("d_left", cur_col, 5);
        for (int t = 0; t < 8; t++) pulse_dir(1'b0);
        check("d_sat_lo", cur_col, 0);
        exp_col[0] = 0;

        // Reset in the middle of SCAN
        @(negedge CLOCK_50); place = 1'b1;
        @(negedge CLOCK_50); place = 1'b0;
        check("e_drop_busy", busy, 1);
        @(negedge CLOCK_50);
        check("e_scan_busy", busy, 1);
        #3 Resetn = 1'b0;
        #1;
        check("e_turn", turn, 0);
        check("e_busy", busy, 0);
        check("e_winner", winner, 0);
        check("e_draw", draw, 0);
        check("e_bad", bad_move, 0);
        check("e_col", cur_col, 3);
        check_cell(0, 0, 0, 2'b00);
        @(negedge CLOCK_50); Resetn = 1'b1;
        exp_col[0] = 3;
        exp_col[1] = 2;
        do_start(0);
        check_cell(0, 0, 0, 2'b00);

        // 4x4 board, WIN_LEN 3, drawn fill
        do_start(1);
        for (int i = 0; i < 16; i++) begin
            place_at(1, seq_f[i], 30, 1'b0);
            check("f_draw", draw4, (i == 15) ? 1 : 0);
        end
        check("f_winner", winner4, 0);
        check_cell(1, 3, 3, 2'b01);
        check_cell(1, 3, 0, 2'b10);
        check_cell(1, 0, 0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
